exec_mem_unit: RTL and testbench
================================

EXEC_MEM_UNIT -- requirements
Module: exec_mem_unit

Interface
- REQ-001 The module SHALL have a single clock, clk (1-bit input); all sequential state SHALL update on its rising edge.
- REQ-002 The module SHALL have rst (1-bit input), an asynchronous, active-high reset.
- REQ-003 The module SHALL have parameter DM_WORDS, default 1024: data-memory depth in 32-bit words, a power of two.
- REQ-004 The module SHALL have ALUctr, input, 4 bits: ALU operation select.
- REQ-005 The module SHALL have ExtOp, input, 2 bits: immediate extension mode.
- REQ-006 The module SHALL have ALUsrc, input, 1 bit: ALU B operand select (0 = busB, 1 = imm32).
- REQ-007 The module SHALL have MemWr, input, 1 bit: data-memory write enable.
- REQ-008 The module SHALL have MemtoReg, input, 1 bit: write-back select (0 = aluResult, 1 = DataOut).
- REQ-009 The module SHALL have busA and busB, inputs, 32 bits each: register operands; busB is also the store data.
- REQ-010 The module SHALL have imm16, input, 16 bits: instruction immediate.
- REQ-011 The module SHALL have imm32, output, 32 bits: extended immediate.
- REQ-012 The module SHALL have aluResult, output, 32 bits: ALU result, which is also the memory byte address.
- REQ-013 The module SHALL have zero, output, 1 bit: asserted when aluResult == 0.
- REQ-014 The module SHALL have DataOut, output, 32 bits: memory read data.
- REQ-015 The module SHALL have busW, output, 32 bits: write-back value.

Function
- REQ-016 imm32 SHALL be computed combinationally from ExtOp:
  - 00 zero-extend imm16;
  - 01 sign-extend imm16;
  - 10 {imm16, 16'h0};
  - 11 zero-extend imm16.
- REQ-017 The ALU SHALL compute A = busA and B = (ALUsrc ? imm32 : busB) combinationally, with no latency.
- REQ-018 aluResult SHALL be selected by ALUctr:
  - 0000 A+B and 0001 A-B, both mod 2^32 with no trap;
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOR;
  - 0110 signed A<B giving 1/0, 0111 unsigned A<B giving 1/0;
  - 1000 B<<A[4:0], 1001 B>>A[4:0] logical, 1010 B>>>A[4:0] arithmetic;
  - 1011 B<<16;
  - 1100..1111 result 0.
- REQ-019 zero SHALL equal (aluResult == 0) for every ALUctr code, including the undefined codes.
- REQ-020 The data memory SHALL be word-organised and indexed by aluResult[log2(DM_WORDS)+1:2]; address bits [1:0] and all higher bits SHALL be ignored, so out-of-range addresses wrap.
- REQ-021 Memory writes SHALL occur on the rising edge of clk when MemWr=1 and rst=0, writing busB to the indexed word.
- REQ-022 DataOut SHALL be an asynchronous (combinational) read of the indexed word.
- REQ-023 When a read and a write target the same address in the same cycle, DataOut SHALL show the old word until the edge and the new word after it.
- REQ-024 busW SHALL equal MemtoReg ? DataOut : aluResult, combinationally.

Reset
- REQ-025 While rst=1, every memory word SHALL be cleared to 0 and writes SHALL be ignored.
- REQ-026 After reset, DataOut SHALL read 0 at any address until that address is written.
- REQ-027 Asserting rst mid-operation SHALL clear memory immediately, without waiting for a clock edge.
- REQ-028 imm32, aluResult, zero and busW SHALL remain functions of the inputs during reset.

Configuration
- REQ-029 With macro EXEC_ALU_OVF_EN defined, the module SHALL add a 1-bit output overflow, asserted on signed two's-complement overflow for ALUctr 0000 and 0001 and 0 for all other codes.
- REQ-030 Without EXEC_ALU_OVF_EN, the overflow port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
- REQ-031 A shared package exec_pkg SHALL hold the ALUctr code localparams and the ExtOp code localparams.
- REQ-032 The data memory SHALL be a single sub-module, exec_dmem, parameterised by DM_WORDS; the extender, ALU and muxes SHALL remain inline.

Verification
- REQ-033 The bench SHALL cover these directed scenarios:
  - Extension: imm16=16'h8001 with ExtOp 00/01/10 -> imm32 = 32'h00008001 / 32'hFFFF8001 / 32'h80010000.
  - Arithmetic: busA=5, busB=7, ALUsrc=0. ALUctr 0001 -> aluResult 32'hFFFFFFFE, zero=0. ALUctr 0110 -> 1. Then busA=busB=9 with ALUctr 0001 -> aluResult 0, zero=1.
  - Shifts: busA=4, busB=32'h80000000. ALUctr 1001 -> 32'h08000000; ALUctr 1010 -> 32'hF8000000.
  - Store/load: ALUsrc=1, ExtOp=01, imm16=16'h0010, busA=0, busB=32'hDEADBEEF, MemWr=1 for one edge. Then MemWr=0, MemtoReg=1 -> busW=32'hDEADBEEF. Address 16'h1010 with DM_WORDS=1024 (wrap) -> same word.
  - Reset: after the store above, pulse rst asynchronously between clock edges -> DataOut=0 immediately. A write attempted with MemWr=1 during rst -> not stored.
  - Overflow (EXEC_ALU_OVF_EN defined): busA=32'h7FFFFFFF, busB=1, ALUctr 0000 -> aluResult 32'h80000000, overflow=1.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: ALU operation and immediate-extension codes shared by the execute/memory stage.
`default_nettype none

package exec_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_HIGH  = 2'b10;
  localparam logic [1:0] EXT_ZERO2 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/exec_dmem.sv
// exec_dmem: word-organised data memory, asynchronous read, synchronous write,
// whole array cleared asynchronously while rst is high.
`default_nettype none

module exec_dmem #(
  parameter int DM_WORDS = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_we,
  input  logic [$clog2(DM_WORDS)-1:0] i_idx,
  input  logic [31:0]                 i_wdata,
  output logic [31:0]                 o_rdata
);

  logic [31:0] r_mem [DM_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Read is combinational, so a same-address write shows up only after the edge.
  assign o_rdata = r_mem[i_idx];

endmodule

`default_nettype wire

// File: rtl/exec_mem_unit.sv
// exec_mem_unit: immediate extender, ALU, data memory and write-back mux.
// Optional signed-overflow output enabled by macro EXEC_ALU_OVF_EN.
`default_nettype none

module exec_mem_unit
  import exec_pkg::*;
#(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ALUctr,
  input  logic [1:0]  ExtOp,
  input  logic        ALUsrc,
  input  logic        MemWr,
  input  logic        MemtoReg,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic [15:0] imm16,
  output logic [31:0] imm32,
  output logic [31:0] aluResult,
  output logic        zero,
  output logic [31:0] DataOut,
  output logic [31:0] busW
`ifdef EXEC_ALU_OVF_EN
  ,
  output logic        overflow
`endif
);

  localparam int AW = $clog2(DM_WORDS);

  logic [31:0] w_b;
  logic [4:0]  w_shamt;

  always_comb begin
    imm32 = {16'h0000, imm16};
    case (ExtOp)
      EXT_ZERO:  imm32 = {16'h0000, imm16};
      EXT_SIGN:  imm32 = {{16{imm16[15]}}, imm16};
      EXT_HIGH:  imm32 = {imm16, 16'h0000};
      EXT_ZERO2: imm32 = {16'h0000, imm16};
      default:   imm32 = {16'h0000, imm16};
    endcase
  end

  assign w_b     = ALUsrc ? imm32 : busB;
  assign w_shamt = busA[4:0];

  always_comb begin
    aluResult = '0;
    case (ALUctr)
      ALU_ADD:  aluResult = busA + w_b;
      ALU_SUB:  aluResult = busA - w_b;
      ALU_AND:  aluResult = busA & w_b;
      ALU_OR:   aluResult = busA | w_b;
      ALU_XOR:  aluResult = busA ^ w_b;
      ALU_NOR:  aluResult = ~(busA | w_b);
      ALU_SLT:  aluResult = {31'b0, $signed(busA) < $signed(w_b)};
      ALU_SLTU: aluResult = {31'b0, busA < w_b};
      ALU_SLL:  aluResult = w_b << w_shamt;
      ALU_SRL:  aluResult = w_b >> w_shamt;
      ALU_SRA:  aluResult = $unsigned($signed(w_b) >>> w_shamt);
      ALU_LUI:  aluResult = w_b << 16;
      default:  aluResult = '0;
    endcase
  end

  assign zero = (aluResult == 32'd0);

`ifdef EXEC_ALU_OVF_EN
  // Overflow when the effective operands agree in sign but the result does not.
  always_comb begin
    overflow = 1'b0;
    case (ALUctr)
      ALU_ADD: overflow = (busA[31] == w_b[31]) && (aluResult[31] != busA[31]);
      ALU_SUB: overflow = (busA[31] != w_b[31]) && (aluResult[31] != busA[31]);
      default: overflow = 1'b0;
    endcase
  end
`endif

  exec_dmem #(
    .DM_WORDS (DM_WORDS)
  ) u_dmem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (MemWr),
    .i_idx   (aluResult[AW+1:2]),
    .i_wdata (busB),
    .o_rdata (DataOut)
  );

  assign busW = MemtoReg ? DataOut : aluResult;

endmodule

`default_nettype wire

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit.
`default_nettype none

module tb_exec_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ALUctr;
  logic [1:0]  ExtOp;
  logic        ALUsrc;
  logic        MemWr;
  logic        MemtoReg;
  logic [31:0] busA;
  logic [31:0] busB;
  logic [15:0] imm16;
  logic [31:0] imm32;
  logic [31:0] aluResult;
  logic        zero;
  logic [31:0] DataOut;
  logic [31:0] busW;
`ifdef EXEC_ALU_OVF_EN
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exec_mem_unit #(.DM_WORDS(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .ALUctr    (ALUctr),
    .ExtOp     (ExtOp),
    .ALUsrc    (ALUsrc),
    .MemWr     (MemWr),
    .MemtoReg  (MemtoReg),
    .busA      (busA),
    .busB      (busB),
    .imm16     (imm16),
    .imm32     (imm32),
    .aluResult (aluResult),
    .zero      (zero),
    .DataOut   (DataOut),
    .busW      (busW)
`ifdef EXEC_ALU_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  task automatic test_reset();
    rst = 1'b1; ALUctr = 4'b0000; ExtOp = 2'b01; ALUsrc = 1'b1;
    MemWr = 1'b0; MemtoReg = 1'b1; busA = 32'd0; busB = 32'd0; imm16 = 16'h0020;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (DataOut !== 32'd0) begin bad++; $display("FAIL reset_dataout got=%h exp=%h", DataOut, 32'd0); end
    total++;
    if (aluResult !== 32'h20) begin bad++; $display("FAIL reset_alu_live got=%h exp=%h", aluResult, 32'h20); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (busW !== 32'd0) begin bad++; $display("FAIL reset_busw got=%h exp=%h", busW, 32'd0); end
  endtask

  task automatic test_extension();
    imm16 = 16'h8001; MemtoReg = 1'b0;
    ExtOp = 2'b00; #1;
    total++;
    if (imm32 !== 32'h00008001) begin bad++; $display("FAIL ext_zero got=%h exp=%h", imm32, 32'h00008001); end
    ExtOp = 2'b01; #1;
    total++;
    if (imm32 !== 32'hFFFF8001) begin bad++; $display("FAIL ext_sign got=%h exp=%h", imm32, 32'hFFFF8001); end
    ExtOp = 2'b10; #1;
    total++;
    if (imm32 !== 32'h80010000) begin bad++; $display("FAIL ext_high got=%h exp=%h", imm32, 32'h80010000); end
    ExtOp = 2'b11; #1;
    total++;
    if (imm32 !== 32'h00008001) begin bad++; $display("FAIL ext_zero2 got=%h exp=%h", imm32, 32'h00008001); end
  endtask

  task automatic test_arith();
    ALUsrc = 1'b0; MemtoReg = 1'b0; busA = 32'd5; busB = 32'd7;
    ALUctr = 4'b0001; #1;
    total++;
    if (aluResult !== 32'hFFFFFFFE || zero !== 1'b0) begin
      bad++; $display("FAIL sub_neg got=%h/%b exp=%h/0", aluResult, zero, 32'hFFFFFFFE);
    end
    ALUctr = 4'b0000; #1;
    total++;
    if (busW !== 32'd12) begin bad++; $display("FAIL add_busw got=%h exp=%h", busW, 32'd12); end
    ALUctr = 4'b0110; #1;
    total++;
    if (aluResult !== 32'd1) begin bad++; $display("FAIL slt got=%h exp=%h", aluResult, 32'd1); end
    busA = 32'hFFFFFFFF; ALUctr = 4'b0110; #1;
    total++;
    if (aluResult !== 32'd1) begin bad++; $display("FAIL slt_neg got=%h exp=%h", aluResult, 32'd1); end
    ALUctr = 4'b0111; #1;
    total++;
    if (aluResult !== 32'd0) begin bad++; $display("FAIL sltu got=%h exp=%h", aluResult, 32'd0); end
    busA = 32'd9; busB = 32'd9; ALUctr = 4'b0001; #1;
    total++;
    if (aluResult !== 32'd0 || zero !== 1'b1) begin
      bad++; $display("FAIL sub_zero got=%h/%b exp=0/1", aluResult, zero);
    end
    busA = 32'hF0F0_1234; busB = 32'h0FF0_00FF;
    ALUctr = 4'b0010; #1;
    total++;
    if (aluResult !== 32'h00F0_0034) begin bad++; $display("FAIL and got=%h exp=%h", aluResult, 32'h00F00034); end
    ALUctr = 4'b0011; #1;
    total++;
    if (aluResult !== 32'hFFF0_12FF) begin bad++; $display("FAIL or got=%h exp=%h", aluResult, 32'hFFF012FF); end
    ALUctr = 4'b0100; #1;
    total++;
    if (aluResult !== 32'hFF00_12CB) begin bad++; $display("FAIL xor got=%h exp=%h", aluResult, 32'hFF0012CB); end
    ALUctr = 4'b0101; #1;
    total++;
    if (aluResult !== 32'h000F_ED00) begin bad++; $display("FAIL nor got=%h exp=%h", aluResult, 32'h000FED00); end
    ALUctr = 4'b1101; #1;
    total++;
    if (aluResult !== 32'd0 || zero !== 1'b1) begin
      bad++; $display("FAIL undef_code got=%h/%b exp=0/1", aluResult, zero);
    end
  endtask

  task automatic test_shifts();
    ALUsrc = 1'b0; busA = 32'd4; busB = 32'h80000000;
    ALUctr = 4'b1001; #1;
    total++;
    if (aluResult !== 32'h08000000) begin bad++; $display("FAIL srl got=%h exp=%h", aluResult, 32'h08000000); end
    ALUctr = 4'b1010; #1;
    total++;
    if (aluResult !== 32'hF8000000) begin bad++; $display("FAIL sra got=%h exp=%h", aluResult, 32'hF8000000); end
    busA = 32'h0000_0024; busB = 32'h0000_0003; ALUctr = 4'b1000; #1;
    total++;
    if (aluResult !== 32'h0000_0030) begin bad++; $display("FAIL sll_mask got=%h exp=%h", aluResult, 32'h30); end
    busB = 32'h0000_ABCD; ALUctr = 4'b1011; #1;
    total++;
    if (aluResult !== 32'hABCD_0000) begin bad++; $display("FAIL lui got=%h exp=%h", aluResult, 32'hABCD0000); end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    ALUsrc = 1'b1; ExtOp = 2'b01; imm16 = 16'h0010; busA = 32'd0; ALUctr = 4'b0000;
    busB = 32'hDEADBEEF; MemWr = 1'b1; MemtoReg = 1'b1;
    #1;
    total++;
    if (DataOut !== 32'd0) begin bad++; $display("FAIL store_old_word got=%h exp=%h", DataOut, 32'd0); end
    @(posedge clk); #1;
    total++;
    if (DataOut !== 32'hDEADBEEF) begin bad++; $display("FAIL store_new_word got=%h exp=%h", DataOut, 32'hDEADBEEF); end
    @(negedge clk);
    imm16 = 16'h0014; busB = 32'h12345678;
    @(negedge clk);
    MemWr = 1'b0; imm16 = 16'h0010; busB = 32'd0;
    #1;
    total++;
    if (busW !== 32'hDEADBEEF) begin bad++; $display("FAIL load_busw got=%h exp=%h", busW, 32'hDEADBEEF); end
    imm16 = 16'h1010; #1;
    total++;
    if (busW !== 32'hDEADBEEF) begin bad++; $display("FAIL load_wrap got=%h exp=%h", busW, 32'hDEADBEEF); end
    imm16 = 16'h0013; #1;
    total++;
    if (DataOut !== 32'hDEADBEEF) begin bad++; $display("FAIL load_lowbits got=%h exp=%h", DataOut, 32'hDEADBEEF); end
    imm16 = 16'h0014; #1;
    total++;
    if (DataOut !== 32'h12345678) begin bad++; $display("FAIL load_neighbour got=%h exp=%h", DataOut, 32'h12345678); end
  endtask

  task automatic test_async_reset();
    imm16 = 16'h1010; MemtoReg = 1'b1; MemWr = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    total++;
    if (DataOut !== 32'd0) begin bad++; $display("FAIL async_clear got=%h exp=%h", DataOut, 32'd0); end
    total++;
    if (aluResult !== 32'h1010) begin bad++; $display("FAIL reset_alu got=%h exp=%h", aluResult, 32'h1010); end
    MemWr = 1'b1; busB = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(negedge clk);
    MemWr = 1'b0; rst = 1'b0; #1;
    total++;
    if (DataOut !== 32'd0) begin bad++; $display("FAIL write_in_reset got=%h exp=%h", DataOut, 32'd0); end
    imm16 = 16'h0014; #1;
    total++;
    if (DataOut !== 32'd0) begin bad++; $display("FAIL other_cleared got=%h exp=%h", DataOut, 32'd0); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ALUsrc = 1'b1; ExtOp = 2'b00; busA = 32'd0; ALUctr = 4'b0000; MemtoReg = 1'b1; MemWr = 1'b1;
    imm16 = 16'h0100; busB = 32'h1111_1111;
    @(negedge clk);
    imm16 = 16'h0104; busB = 32'h2222_2222;
    @(negedge clk);
    MemWr = 1'b0; imm16 = 16'h0100; #1;
    total++;
    if (busW !== 32'h1111_1111) begin bad++; $display("FAIL b2b_first got=%h exp=%h", busW, 32'h11111111); end
    imm16 = 16'h0104; #1;
    total++;
    if (busW !== 32'h2222_2222) begin bad++; $display("FAIL b2b_second got=%h exp=%h", busW, 32'h22222222); end
  endtask

`ifdef EXEC_ALU_OVF_EN
  task automatic test_overflow();
    ALUsrc = 1'b0; MemtoReg = 1'b0; busA = 32'h7FFFFFFF; busB = 32'd1; ALUctr = 4'b0000; #1;
    total++;
    if (aluResult !== 32'h80000000 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_add got=%h/%b exp=80000000/1", aluResult, overflow);
    end
    busA = 32'h80000000; ALUctr = 4'b0001; #1;
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sub got=%b exp=1", overflow); end
    ALUctr = 4'b0011; #1;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_other got=%b exp=0", overflow); end
  endtask
`endif

  initial begin
    test_reset();
    test_extension();
    test_arith();
    test_shifts();
    test_store_load();
    test_async_reset();
    test_back_to_back();
`ifdef EXEC_ALU_OVF_EN
    test_overflow();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
